// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared divisor helpers for the dual clock divider
package clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    // Divisors below MIN_DIV would collapse the waveform, so they run as MIN_DIV.
    function automatic int unsigned eff_div(input int unsigned d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    // High phase length: the extra cycle of an odd divisor goes to the high phase.
    function automatic int unsigned hi_len(input int unsigned d);
        return d - d / 2;
    endfunction

endpackage

// File: rtl/div_channel.sv
// rtl/div_channel.sv - one divided-clock channel with shadowed divisor reload
module div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    output logic             clk_out,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] active_next;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] hi_next;
    logic             pending;
    logic             live;

    // Period bookkeeping: wrap detection, divisor swap at the boundary, next count.
    always_comb begin
        last_cnt    = CNT_W'(eff_div(32'(active)) - 1);
        wrap        = en && live && (cnt == last_cnt);
        active_next = (wrap && pending) ? shadow : active;
        hi_next     = CNT_W'(hi_len(eff_div(32'(active_next))));
        if (!en || !live || wrap) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // State update; live marks that the previous edge was already running so the
    // first enabled edge starts a fresh period at count 0 with the output high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            live    <= 1'b0;
            active  <= CNT_W'(DEF_DIV);
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            clk_out <= en && (cnt_next < hi_next);
            live    <= en;
            active  <= active_next;
            if (load) begin
                shadow  <= div_in;
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dual_clk_div.sv
// rtl/dual_clk_div.sv - dual programmable clock divider with mux select and load ack
module dual_clk_div
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int DEF_DIV_A = 4,
    parameter int DEF_DIV_B = 6,
    parameter int SEL_CYC   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_a_in,
    input  logic [CNT_W-1:0] div_b_in,
    input  logic             load,
    output logic             load_ack,
    output logic             clk1,
    output logic             clk2,
    output logic             sel
);

    localparam int SEL_W = $clog2(SEL_CYC + 1);

    logic             wrap_a;
    logic             wrap_b;
    logic [SEL_W-1:0] sel_cnt;
    logic             ack_due;
    logic             done_a;
    logic             done_b;

    div_channel #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV_A)) u_chan_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .div_in  (div_a_in),
        .clk_out (clk1),
        .wrap    (wrap_a)
    );

    div_channel #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV_B)) u_chan_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .div_in  (div_b_in),
        .clk_out (clk2),
        .wrap    (wrap_b)
    );

    // Toggle sel every SEL_CYC clk1 wraps so the mux only switches at period edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_cnt <= '0;
            sel     <= 1'b0;
        end else if (wrap_a) begin
            if (sel_cnt == SEL_W'(SEL_CYC - 1)) begin
                sel_cnt <= '0;
                sel     <= ~sel;
            end else begin
                sel_cnt <= sel_cnt + SEL_W'(1);
            end
        end
    end

    // A channel has adopted the latest load at its first wrap after that load; a load
    // coinciding with a wrap restarts tracking because that wrap takes the old values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_due  <= 1'b0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (load) begin
                ack_due <= 1'b1;
                done_a  <= 1'b0;
                done_b  <= 1'b0;
            end else begin
                if (wrap_a) done_a <= 1'b1;
                if (wrap_b) done_b <= 1'b1;
                if (ack_due && done_a && done_b) begin
                    load_ack <= 1'b1;
                    ack_due  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_clk_div.sv
// tb/tb_dual_clk_div.sv - self-checking bench for dual_clk_div
module tb_dual_clk_div;

    localparam int SEL_CYC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] div_a_in;
    logic [7:0] div_b_in;
    logic       load;
    logic       load_ack;
    logic       clk1;
    logic       clk2;
    logic       sel;

    int tests = 0;
    int fails = 0;
    int ack_seen = 0;

    // Reference state: position within the current period (-1 = idle), raw divisors.
    int ph_a, ph_b, da, db, sa, sb, selc;
    bit pa, pb, ack_due, sel_m, ack_m;

    dual_clk_div #(.CNT_W(8), .DEF_DIV_A(4), .DEF_DIV_B(6), .SEL_CYC(SEL_CYC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_a_in (div_a_in),
        .div_b_in (div_b_in),
        .load     (load),
        .load_ack (load_ack),
        .clk1     (clk1),
        .clk2     (clk2),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    function automatic int ef(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic bit high(input int ph, input int d);
        return (ph >= 0) && (ph < (ef(d) + 1) / 2);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit l, input int a, input int b);
        bit wa, wb;
        if (!r) begin
            ph_a = -1; ph_b = -1; da = 4; db = 6; sa = 0; sb = 0;
            pa = 0; pb = 0; ack_due = 0; selc = 0; sel_m = 0; ack_m = 0;
        end else begin
            ack_m = ack_due && !pa && !pb && !l;
            if (ack_m) ack_due = 0;
            wa = e && ph_a >= 0 && ph_a == ef(da) - 1;
            wb = e && ph_b >= 0 && ph_b == ef(db) - 1;
            if (!e) ph_a = -1; else if (ph_a < 0 || wa) ph_a = 0; else ph_a++;
            if (!e) ph_b = -1; else if (ph_b < 0 || wb) ph_b = 0; else ph_b++;
            if (wa && pa) begin da = sa; pa = 0; end
            if (wb && pb) begin db = sb; pb = 0; end
            if (l) begin sa = a; sb = b; pa = 1; pb = 1; ack_due = 1; end
            if (wa) begin
                selc++;
                if (selc == SEL_CYC) begin selc = 0; sel_m = !sel_m; end
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit l, input int a, input int b);
        rst_n = r; en = e; load = l; div_a_in = 8'(a); div_b_in = 8'(b);
        @(posedge clk);
        model(r, e, l, a, b);
        #1;
        chk("clk1", clk1, high(ph_a, da));
        chk("clk2", clk2, high(ph_b, db));
        chk("sel", sel, sel_m);
        chk("load_ack", load_ack, ack_m);
        if (load_ack === 1'b1) ack_seen++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0);
    endtask

    initial begin
        int acks0;
        // Reset state
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("rst_clk1", clk1, 1'b0);
        chk("rst_clk2", clk2, 1'b0);
        chk("rst_sel", sel, 1'b0);
        chk("rst_ack", load_ack, 1'b0);

        // Defaults 4/6 after reset release, against literal waveforms
        for (int i = 0; i < 24; i++) begin
            step(1, 1, 0, 0, 0);
            chk("lit_clk1", clk1, logic'((i % 4) < 2));
            chk("lit_clk2", clk2, logic'((i % 6) < 3));
            chk("lit_sel", sel, logic'((i / 8) % 2));
        end

        // div_a=5 loaded at cycle 1 of a clk1 period
        acks0 = ack_seen;
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 5, 6);
        run(24);
        chk("ack_once_5", logic'(ack_seen - acks0 == 1), 1'b1);

        // Divisors 0 and 1 clamp to 2
        acks0 = ack_seen;
        step(1, 1, 1, 0, 1);
        run(20);
        chk("ack_once_clamp", logic'(ack_seen - acks0 == 1), 1'b1);
        chk("clamp_clk1_alt", logic'(clk1 != clk2 || clk1 == clk2), 1'b1);

        // Back-to-back loads: only the later one applies, one ack
        acks0 = ack_seen;
        step(1, 1, 1, 6, 6);
        run(12);
        acks0 = ack_seen;
        step(1, 1, 1, 8, 8);
        run(1);
        step(1, 1, 1, 3, 3);
        run(30);
        chk("ack_once_double", logic'(ack_seen - acks0 == 1), 1'b1);

        // en dropped for 5 cycles then re-asserted: outputs restart in phase
        run(3);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0);
            chk("dis_clk1", clk1, 1'b0);
            chk("dis_clk2", clk2, 1'b0);
        end
        step(1, 1, 0, 0, 0);
        chk("reen_clk1", clk1, 1'b1);
        chk("reen_clk2", clk2, 1'b1);
        run(12);

        // Reset with a load pending: no ack, defaults return
        step(1, 1, 1, 9, 9);
        run(1);
        acks0 = ack_seen;
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            step(1, 1, 0, 0, 0);
            chk("rst2_clk1", clk1, logic'((i % 4) < 2));
            chk("rst2_clk2", clk2, logic'((i % 6) < 3));
        end
        chk("no_ack_after_rst", logic'(ack_seen == acks0), 1'b1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9),
                 $urandom_range(0, 9));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dual_clk_div.md
Name: dual_clk_div

Overview:
Programmable dual clock-divider stage that sits directly upstream of the clock-mux stage. It generates the two candidate divided clocks, clk1 and clk2, from the single system clock. It also generates the select signal sel that drives the mux. Divisors are reloaded through a load/ack handshake and only take effect on period boundaries, so the outputs never produce runt pulses.

Parameters:
CNT_W, 8, width of divisor inputs and internal period counters
DEF_DIV_A, 4, clk1 divisor after reset
DEF_DIV_B, 6, clk2 divisor after reset
SEL_CYC, 2, number of complete clk1 periods between sel toggles (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset; synchronous, active-low
en  input  1  run enable
div_a_in  input  CNT_W  new clk1 divisor, sampled when load=1
div_b_in  input  CNT_W  new clk2 divisor, sampled when load=1
load  input  1  single-cycle request to capture div_a_in/div_b_in
load_ack  output  1  single-cycle pulse when both channels run the new divisors
clk1  output  1  divided clock A (registered)
clk2  output  1  divided clock B (registered)
sel  output  1  mux select, registered

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - clk1=0, clk2=0, sel=0, load_ack=0.
  - Counters=0; active divisors = DEF_DIV_A / DEF_DIV_B; shadow regs cleared; pending flags cleared.
- Effective divisor: D = max(divisor, 2), so values 0 and 1 behave as 2.
- Per-channel waveform:
  - Define H = D - floor(D/2).
  - Counter runs 0..D-1 and wraps.
  - Output = 1 while counter < H, else 0. The output is registered from the next-count value.
  - First edge with rst_n=1 and en=1 drives the output to 1.
  - Resulting waveform: high H cycles, low D-H cycles, period D.
  - Example D=5 gives 11100 repeating.
- en=0:
  - Counters forced to 0; clk1=clk2=0; the sel counter holds; sel holds.
  - Pending loads remain pending.
  - On re-enable, both channels start a fresh period in the same cycle (in phase).
- Load handshake:
  - load=1 captures div_a_in/div_b_in into shadow regs and sets pending_a and pending_b.
  - A channel applies its shadow divisor on its own wrap: the edge where the counter goes D-1 -> 0. The new period starts with the new D; the old period always completes.
  - load_ack pulses for 1 cycle, on the edge after both pending flags have cleared.
  - load while pending: shadow overwritten and both flags re-set; only one ack is issued, for the latest values.
  - load on the same edge as a channel's wrap: that wrap applies the old shadow, and the flag re-sets for the new value.
  - load while en=0: captured; applied at the wraps after re-enable.
- sel:
  - A counter counts clk1 wraps.
  - sel toggles on the edge where clk1's counter wraps for the SEL_CYC-th time since the last toggle; the counter then restarts.
  - Toggling is aligned to a clk1 period boundary, so the downstream mux switches only at period edges.
- Reset mid-operation takes priority over en and load: everything returns to reset values on that edge, and any pending load is discarded.
- Arithmetic:
  - Counters are CNT_W bits.
  - The compare uses D-1 computed in CNT_W bits; there is no overflow because D>=2.
  - The sel counter width is clog2(SEL_CYC+1).

Decomposition:
- Shared package clk_div_pkg:
  - constant MIN_DIV=2;
  - function eff_div(d), the clamp to >=2;
  - function hi_len(d) = d - d/2.
- Sub-module div_channel, instantiated twice. It contains:
  - counter and output register;
  - active and shadow divisor;
  - pending flag;
  - a wrap-strobe output, which is used for sel and ack.
- The top level holds the sel counter, the load_ack logic and the en gating.

Test Plan:
- Reset release with en=1 and defaults 4/6: clk1 = 1100 repeating; clk2 = 111000 repeating; sel=0 for 8 cycles, then toggles every 8 cycles (SEL_CYC=2).
- div_a_in=5 with load pulsed at cycle 1 of a clk1 period: current 1100 period completes, then 11100 repeating. load_ack pulses once, on the edge after clk2's next wrap (the later of the two).
- load with div_a_in=0 and div_b_in=1: both outputs become 10 repeating after their wraps; one load_ack pulse.
- Two loads 2 cycles apart (first 8, then 3) before either channel wraps: only 3 is ever applied (111000 on clk1 with D_b=3 -> 110); exactly one ack.
- en dropped mid-period for 5 cycles: clk1=clk2=0 and sel frozen. On re-assert, both outputs go high on the same edge and restart full periods.
- rst_n=0 for one cycle mid-operation with a load pending: all outputs 0, divisors revert to 4/6, no load_ack; the next period restarts per the first scenario.
